// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port register file: default geometry and RV32I ABI register indices.
// Latency: n/a (constants only).
// Backpressure: n/a.
package rf_pkg;

  localparam int RF_DATA_W_DEF = 32;
  localparam int RF_NUMBER_DEF = 32;
  localparam int RF_ABI_W      = 5;

  // RV32I ABI register names mapped to architectural indices
  localparam logic [RF_ABI_W-1:0] ZERO = 5'd0;
  localparam logic [RF_ABI_W-1:0] RA   = 5'd1;
  localparam logic [RF_ABI_W-1:0] SP   = 5'd2;
  localparam logic [RF_ABI_W-1:0] GP   = 5'd3;
  localparam logic [RF_ABI_W-1:0] TP   = 5'd4;
  localparam logic [RF_ABI_W-1:0] T0   = 5'd5;
  localparam logic [RF_ABI_W-1:0] T1   = 5'd6;
  localparam logic [RF_ABI_W-1:0] T2   = 5'd7;
  localparam logic [RF_ABI_W-1:0] S0   = 5'd8;
  localparam logic [RF_ABI_W-1:0] S1   = 5'd9;
  localparam logic [RF_ABI_W-1:0] A0   = 5'd10;
  localparam logic [RF_ABI_W-1:0] A1   = 5'd11;
  localparam logic [RF_ABI_W-1:0] A2   = 5'd12;
  localparam logic [RF_ABI_W-1:0] A3   = 5'd13;
  localparam logic [RF_ABI_W-1:0] A4   = 5'd14;
  localparam logic [RF_ABI_W-1:0] A5   = 5'd15;
  localparam logic [RF_ABI_W-1:0] A6   = 5'd16;
  localparam logic [RF_ABI_W-1:0] A7   = 5'd17;
  localparam logic [RF_ABI_W-1:0] S2   = 5'd18;
  localparam logic [RF_ABI_W-1:0] S3   = 5'd19;
  localparam logic [RF_ABI_W-1:0] S4   = 5'd20;
  localparam logic [RF_ABI_W-1:0] S5   = 5'd21;
  localparam logic [RF_ABI_W-1:0] S6   = 5'd22;
  localparam logic [RF_ABI_W-1:0] S7   = 5'd23;
  localparam logic [RF_ABI_W-1:0] S8   = 5'd24;
  localparam logic [RF_ABI_W-1:0] S9   = 5'd25;
  localparam logic [RF_ABI_W-1:0] S10  = 5'd26;
  localparam logic [RF_ABI_W-1:0] S11  = 5'd27;
  localparam logic [RF_ABI_W-1:0] T3   = 5'd28;
  localparam logic [RF_ABI_W-1:0] T4   = 5'd29;
  localparam logic [RF_ABI_W-1:0] T5   = 5'd30;
  localparam logic [RF_ABI_W-1:0] T6   = 5'd31;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-result scoreboard: one pending bit per register plus a running count of pending registers.
// Latency: set/clear take effect at the next rising edge; outputs are registered.
// Backpressure: none, every presented set/clear is accepted.
// Ports: i_clk/i_sres clock and sync reset; i_set_vld/i_set_idx mark pending;
//        i_clr_vld/i_clr_idx clear pending (result written); o_pending vector; o_pend_cnt popcount.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int REG_NUMBER = RF_NUMBER_DEF,
  parameter int ADDR_WIDTH = $clog2(REG_NUMBER),
  parameter int CNT_W      = $clog2(REG_NUMBER + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_sres,
  input  logic                  i_set_vld,
  input  logic [ADDR_WIDTH-1:0] i_set_idx,
  input  logic                  i_clr_vld,
  input  logic [ADDR_WIDTH-1:0] i_clr_idx,
  output logic [REG_NUMBER-1:0] o_pending,
  output logic [CNT_W-1:0]      o_pend_cnt
);

  logic [REG_NUMBER-1:0] r_pending;
  logic [CNT_W-1:0]      r_pend_cnt;
  logic [REG_NUMBER-1:0] w_pending_nxt;
  logic                  w_set_hit;
  logic                  w_clr_hit;
  logic                  w_inc;
  logic                  w_dec;

  always_comb begin
    w_set_hit = i_set_vld & (i_set_idx != '0);
    w_clr_hit = i_clr_vld & (i_clr_idx != '0);
    // Count moves only on real state transitions of a bit.
    w_inc = w_set_hit & ~r_pending[i_set_idx];
    // A set to the same index overrides the clear, so that bit stays pending.
    w_dec = w_clr_hit & r_pending[i_clr_idx] & ~(w_set_hit & (i_set_idx == i_clr_idx));
    w_pending_nxt = r_pending;
    if (w_clr_hit) w_pending_nxt[i_clr_idx] = 1'b0;
    if (w_set_hit) w_pending_nxt[i_set_idx] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_sres) begin
      r_pending  <= '0;
      r_pend_cnt <= '0;
    end else begin
      r_pending <= w_pending_nxt;
      if (w_inc && !w_dec)      r_pend_cnt <= r_pend_cnt + CNT_W'(1);
      else if (w_dec && !w_inc) r_pend_cnt <= r_pend_cnt - CNT_W'(1);
    end
  end

  assign o_pending  = r_pending;
  assign o_pend_cnt = r_pend_cnt;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with x0 hardwired to zero, optional write-to-read bypass and a pending scoreboard.
// Latency: reads combinational (zero cycles); writes and scoreboard updates land at the rising edge.
// Backpressure: none; rf_cs=0 blanks all reads and freezes all state.
// Ports: rf_clk/rf_sres clock and sync reset; rf_cs chip select; wr_en/rw_dec/w_data_in write port;
//        rd_dec/rd_data/rd_valid packed read ports; sb_set/sb_dec mark pending; pend_cnt pending count.
module regfile_mp
  import rf_pkg::*;
#(
  parameter int REG_DATA_W = RF_DATA_W_DEF,
  parameter int REG_NUMBER = RF_NUMBER_DEF,
  parameter int ADDR_WIDTH = $clog2(REG_NUMBER),
  parameter int NUM_RD     = 2,
  parameter bit BYPASS_EN  = 1'b1
) (
  input  logic                             rf_clk,
  input  logic                             rf_sres,
  input  logic                             rf_cs,
  input  logic                             wr_en,
  input  logic [ADDR_WIDTH-1:0]            rw_dec,
  input  logic [REG_DATA_W-1:0]            w_data_in,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]     rd_dec,
  output logic [NUM_RD*REG_DATA_W-1:0]     rd_data,
  output logic [NUM_RD-1:0]                rd_valid,
  input  logic                             sb_set,
  input  logic [ADDR_WIDTH-1:0]            sb_dec,
  output logic [$clog2(REG_NUMBER+1)-1:0]  pend_cnt
);

  logic [REG_DATA_W-1:0] r_regs [REG_NUMBER];
  logic [REG_NUMBER-1:0] w_pending;
  logic                  w_we;

  assign w_we = rf_cs & wr_en & (rw_dec != '0);

  // Entry 0 is never written, so it holds the reset value of zero forever.
  always_ff @(posedge rf_clk) begin
    if (rf_sres) begin
      for (int i = 0; i < REG_NUMBER; i++) r_regs[i] <= '0;
    end else if (w_we) begin
      r_regs[rw_dec] <= w_data_in;
    end
  end

  rf_scoreboard #(
    .REG_NUMBER (REG_NUMBER),
    .ADDR_WIDTH (ADDR_WIDTH),
    .CNT_W      ($clog2(REG_NUMBER + 1))
  ) u_sb (
    .i_clk      (rf_clk),
    .i_sres     (rf_sres),
    .i_set_vld  (rf_cs & sb_set),
    .i_set_idx  (sb_dec),
    .i_clr_vld  (rf_cs & wr_en),
    .i_clr_idx  (rw_dec),
    .o_pending  (w_pending),
    .o_pend_cnt (pend_cnt)
  );

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] w_idx;
    logic                  w_hit;
    logic                  w_zero;

    assign w_idx  = rd_dec[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_zero = (w_idx == '0);
    // w_we already excludes index 0, so a bypass hit never targets x0.
    assign w_hit  = BYPASS_EN & w_we & (rw_dec == w_idx);

    always_comb begin
      rd_data[k*REG_DATA_W +: REG_DATA_W] = '0;
      rd_valid[k]                         = 1'b0;
      if (rf_cs) begin
        if (w_hit)        rd_data[k*REG_DATA_W +: REG_DATA_W] = w_data_in;
        else if (!w_zero) rd_data[k*REG_DATA_W +: REG_DATA_W] = r_regs[w_idx];
        rd_valid[k] = w_zero | ~w_pending[w_idx] | w_hit;
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  logic        rf_clk = 1'b0;
  logic        rf_sres, rf_cs, wr_en, sb_set;
  logic [4:0]  rw_dec, sb_dec, rd0, rd1;
  logic [31:0] w_data_in;
  logic [9:0]  rd_dec;
  logic [63:0] rd_data, nb_rd_data;
  logic [1:0]  rd_valid, nb_rd_valid;
  logic [5:0]  pend_cnt, nb_pend_cnt;

  int checks = 0;
  int errors = 0;

  assign rd_dec = {rd1, rd0};

  always #5 rf_clk = ~rf_clk;

  regfile_mp dut (
    .rf_clk(rf_clk), .rf_sres(rf_sres), .rf_cs(rf_cs), .wr_en(wr_en),
    .rw_dec(rw_dec), .w_data_in(w_data_in), .rd_dec(rd_dec),
    .rd_data(rd_data), .rd_valid(rd_valid), .sb_set(sb_set),
    .sb_dec(sb_dec), .pend_cnt(pend_cnt)
  );

  regfile_mp #(.BYPASS_EN(1'b0)) dut_nb (
    .rf_clk(rf_clk), .rf_sres(rf_sres), .rf_cs(rf_cs), .wr_en(wr_en),
    .rw_dec(rw_dec), .w_data_in(w_data_in), .rd_dec(rd_dec),
    .rd_data(nb_rd_data), .rd_valid(nb_rd_valid), .sb_set(sb_set),
    .sb_dec(sb_dec), .pend_cnt(nb_pend_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then leave time so new inputs settle before sampling.
  task automatic tick();
    @(posedge rf_clk);
    #2;
  endtask

  initial begin
    rf_sres = 1'b1; rf_cs = 1'b0; wr_en = 1'b0; sb_set = 1'b0;
    rw_dec = '0; sb_dec = '0; rd0 = '0; rd1 = '0; w_data_in = '0;
    tick();
    tick();
    rf_sres = 1'b0; rf_cs = 1'b1; rd0 = 5'd5; rd1 = 5'd0;
    #1;
    chk("reset_pend", 64'(pend_cnt), 64'd0);
    chk("reset_data", rd_data, 64'h0);
    chk("reset_valid", 64'(rd_valid), 64'h3);

    // write x5, read back next cycle
    wr_en = 1'b1; rw_dec = 5'd5; w_data_in = 32'hDEADBEEF;
    tick();
    wr_en = 1'b0;
    #1;
    chk("x5_x0_data", rd_data, 64'h00000000_DEADBEEF);
    chk("x5_x0_valid", 64'(rd_valid), 64'h3);
    chk("nb_x5_data", nb_rd_data, 64'h00000000_DEADBEEF);

    // same-cycle bypass of x7
    rd0 = 5'd7; wr_en = 1'b1; rw_dec = 5'd7; w_data_in = 32'h12345678;
    #1;
    chk("bypass_x7", 64'(rd_data[31:0]), 64'h12345678);
    chk("nobypass_x7_old", 64'(nb_rd_data[31:0]), 64'h0);
    tick();
    wr_en = 1'b0;
    #1;
    chk("nobypass_x7_new", 64'(nb_rd_data[31:0]), 64'h12345678);

    // scoreboard sets x10, x11, x10
    sb_set = 1'b1; sb_dec = 5'd10;
    tick();
    #1 chk("pend_after_x10", 64'(pend_cnt), 64'd1);
    sb_dec = 5'd11;
    tick();
    #1 chk("pend_after_x11", 64'(pend_cnt), 64'd2);
    sb_dec = 5'd10;
    tick();
    sb_set = 1'b0; rd0 = 5'd10; rd1 = 5'd11;
    #1;
    chk("pend_reset_x10", 64'(pend_cnt), 64'd2);
    chk("valid_pending", 64'(rd_valid), 64'h0);
    wr_en = 1'b1; rw_dec = 5'd10; w_data_in = 32'h1;
    #1;
    chk("valid_bypass_hit", 64'(rd_valid), 64'h1);
    chk("nb_valid_no_hit", 64'(nb_rd_valid), 64'h0);
    tick();
    wr_en = 1'b0;
    #1;
    chk("pend_after_wr_x10", 64'(pend_cnt), 64'd1);
    chk("valid_after_wr_x10", 64'(rd_valid), 64'h1);
    chk("data_x10", 64'(rd_data[31:0]), 64'h1);

    // simultaneous set and write of x3: write lands, set wins
    sb_set = 1'b1; sb_dec = 5'd3; wr_en = 1'b1; rw_dec = 5'd3; w_data_in = 32'hA5;
    tick();
    sb_set = 1'b0; wr_en = 1'b0; rd0 = 5'd3;
    #1;
    chk("x3_data", 64'(rd_data[31:0]), 64'hA5);
    chk("x3_pending", 64'(rd_valid[0]), 64'h0);
    chk("pend_x3", 64'(pend_cnt), 64'd2);

    // writing x0 is ignored
    rd0 = 5'd0; wr_en = 1'b1; rw_dec = 5'd0; w_data_in = 32'hFFFFFFFF;
    #1 chk("x0_during_wr", 64'(rd_data[31:0]), 64'h0);
    tick();
    wr_en = 1'b0;
    #1;
    chk("x0_after_wr", 64'(rd_data[31:0]), 64'h0);
    chk("x0_valid", 64'(rd_valid[0]), 64'h1);

    // set on one index while clearing another: net count unchanged
    sb_set = 1'b1; sb_dec = 5'd20; wr_en = 1'b1; rw_dec = 5'd11; w_data_in = 32'h11;
    tick();
    #1 chk("pend_net_zero", 64'(pend_cnt), 64'd2);
    sb_dec = 5'd21; wr_en = 1'b0;
    tick();
    sb_dec = 5'd22;
    tick();
    sb_dec = 5'd23;
    tick();
    sb_set = 1'b0;
    #1 chk("pend_four_plus", 64'(pend_cnt), 64'd5);

    // reset with concurrent write and set
    rf_sres = 1'b1; wr_en = 1'b1; rw_dec = 5'd9; w_data_in = 32'h55;
    sb_set = 1'b1; sb_dec = 5'd24;
    tick();
    rf_sres = 1'b0; wr_en = 1'b0; sb_set = 1'b0; rd0 = 5'd9; rd1 = 5'd3;
    #1;
    chk("rst_pend", 64'(pend_cnt), 64'd0);
    chk("rst_data", rd_data, 64'h0);
    chk("rst_valid", 64'(rd_valid), 64'h3);

    // chip-select low: outputs blank, no state change
    wr_en = 1'b1; rw_dec = 5'd12; w_data_in = 32'h77; rd0 = 5'd12; rd1 = 5'd12;
    tick();
    rf_cs = 1'b0; w_data_in = 32'h99; sb_set = 1'b1; sb_dec = 5'd12;
    #1;
    chk("cs0_data", rd_data, 64'h0);
    chk("cs0_valid", 64'(rd_valid), 64'h0);
    tick();
    rf_cs = 1'b1; wr_en = 1'b0; sb_set = 1'b0;
    #1;
    chk("cs1_data", rd_data, 64'h00000077_00000077);
    chk("cs1_valid", 64'(rd_valid), 64'h3);
    chk("cs1_pend", 64'(pend_cnt), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
